// File: rtl/id_auth_pkg.sv
// id_auth_pkg: shared types and constants for the ID authenticator.
//   authState_t     - controller state encoding
//   SENTINEL_ALL    - all-ones end-of-table marker, sliced to ID_W by users
//   DEF_GUEST_DIGIT - digit repeated to form the default guest ID
//   DEF_GUEST_ID    - default guest ID at 4x4-bit digits (16'h8888)
package id_auth_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    WAIT,
    COMPARE,
    MATCH,
    LOCKED
  } authState_t;

  localparam int unsigned MAX_ID_W = 64;
  localparam logic [MAX_ID_W-1:0] SENTINEL_ALL = '1;

  localparam logic [3:0]  DEF_GUEST_DIGIT = 4'h8;
  localparam logic [15:0] DEF_GUEST_ID    = {4{DEF_GUEST_DIGIT}};

endpackage

// File: rtl/id_lockout_timer.sv
// id_lockout_timer: counts consecutive failed searches and runs the lockout window.
// Ports:
//   clk, rst      - clock, async active-low reset
//   fail_pulse    - one search ended without a match
//   match_pulse   - one search ended with a match (clears the fail count)
//   start         - begin lockout (issued together with the fail that reaches MAX_FAILS)
//   locked        - lockout active (registered)
//   lock_arm_c    - the next fail will reach MAX_FAILS
//   lock_done_c   - lockout ends on this edge
module id_lockout_timer #(
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic fail_pulse,
  input  logic match_pulse,
  input  logic start,
  output logic locked,
  output logic lock_arm_c,
  output logic lock_done_c
);

  localparam int unsigned FCNT_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LCNT_W = $clog2(LOCK_CYCLES + 1);

  logic [FCNT_W-1:0] failCnt;
  logic [LCNT_W-1:0] lockCnt;

  assign lock_arm_c  = (failCnt == FCNT_W'(MAX_FAILS - 1));
  assign lock_done_c = locked && (lockCnt == LCNT_W'(LOCK_CYCLES - 1));

  // Fail counter saturates at MAX_FAILS; lockout clears it on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      failCnt <= '0;
      lockCnt <= '0;
      locked  <= 1'b0;
    end else if (locked) begin
      if (lock_done_c) begin
        locked  <= 1'b0;
        failCnt <= '0;
        lockCnt <= '0;
      end else begin
        lockCnt <= lockCnt + LCNT_W'(1);
      end
    end else if (start) begin
      locked  <= 1'b1;
      lockCnt <= '0;
      failCnt <= FCNT_W'(MAX_FAILS);
    end else if (fail_pulse) begin
      if (failCnt != FCNT_W'(MAX_FAILS)) begin
        failCnt <= failCnt + FCNT_W'(1);
      end
    end else if (match_pulse) begin
      failCnt <= '0;
    end
  end

endmodule

// File: rtl/id_authenticator.sv
// id_authenticator: collects a DIGITS-long ID, scans a synchronous ID ROM for it,
// and reports the matching player address and guest flag, with failed-attempt lockout.
// Optional feature: define IDAUTH_GUEST_EN to compile in the guest comparator;
// otherwise is_guest stays 0 and the guest entry is an ordinary player.
// Ports:
//   clk, rst      - clock, async active-low reset
//   digit_in      - digit value, taken on digit_strobe
//   digit_strobe  - accept digit_in (ENTRY only)
//   digit_clear   - discard partial entry (ENTRY only, wins over strobe)
//   logout        - end matched session (MATCH only)
//   rom_addr      - registered ROM address
//   rom_data      - ROM word, valid ROM_LAT cycles after rom_addr changes
//   matched       - ID accepted, held until logout
//   player_addr   - address of the matching entry
//   is_guest      - matching entry equals GUEST_ID
//   locked        - lockout active
//   busy          - search in progress
module id_authenticator
  import id_auth_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned ROM_LAT     = 2,
  parameter logic [DIGITS*DIGIT_W-1:0] GUEST_ID = {DIGITS{DIGIT_W'(DEF_GUEST_DIGIT)}},
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGIT_W-1:0]        digit_in,
  input  logic                      digit_strobe,
  input  logic                      digit_clear,
  input  logic                      logout,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DIGITS*DIGIT_W-1:0] rom_data,
  output logic                      matched,
  output logic [ADDR_W-1:0]         player_addr,
  output logic                      is_guest,
  output logic                      locked,
  output logic                      busy
);

  localparam int unsigned ID_W   = DIGITS * DIGIT_W;
  localparam int unsigned DCNT_W = $clog2(DIGITS + 1);
  localparam int unsigned WCNT_W = $clog2(ROM_LAT + 1);
  localparam logic [ID_W-1:0] SENTINEL = SENTINEL_ALL[ID_W-1:0];

  // Configuration sanity: zero latency/threshold or an unreachable guest ID are build errors.
  if (ROM_LAT < 1 || MAX_FAILS < 1 || LOCK_CYCLES < 1 || GUEST_ID == SENTINEL) begin : gBadCfg
    $error("id_authenticator: invalid parameter set");
  end

  authState_t        state;
  logic [ID_W-1:0]   idReg;
  logic [DCNT_W-1:0] digitCnt;
  logic [WCNT_W-1:0] waitCnt;

  logic isSentinel;
  logic isHit;
  logic atLast;
  logic failPulse;
  logic matchPulse;
  logic lockStart;
  logic lockArm;
  logic lockDone;

  // Compare-stage decode: sentinel beats a hit, so an all-ones ID never matches.
  always_comb begin
    isSentinel = (rom_data == SENTINEL);
    isHit      = (rom_data == idReg);
    atLast     = (rom_addr == '1);
    failPulse  = (state == COMPARE) && (isSentinel || (!isHit && atLast));
    matchPulse = (state == COMPARE) && !isSentinel && isHit;
    lockStart  = failPulse && lockArm;
  end

  id_lockout_timer #(
    .MAX_FAILS  (MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) uTimer (
    .clk        (clk),
    .rst        (rst),
    .fail_pulse (failPulse),
    .match_pulse(matchPulse),
    .start      (lockStart),
    .locked     (locked),
    .lock_arm_c (lockArm),
    .lock_done_c(lockDone)
  );

  // Controller: entry, ROM walk, session hold and lockout wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ENTRY;
      idReg       <= '0;
      digitCnt    <= '0;
      waitCnt     <= '0;
      rom_addr    <= '0;
      matched     <= 1'b0;
      player_addr <= '0;
      is_guest    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (digit_clear) begin
            digitCnt <= '0;
          end else if (digit_strobe) begin
            // First digit ends up in the MSBs after DIGITS shifts.
            idReg <= ID_W'({idReg, digit_in});
            if (digitCnt == DCNT_W'(DIGITS - 1)) begin
              digitCnt <= '0;
              rom_addr <= '0;
              waitCnt  <= '0;
              busy     <= 1'b1;
              state    <= WAIT;
            end else begin
              digitCnt <= digitCnt + DCNT_W'(1);
            end
          end
        end

        WAIT: begin
          if (waitCnt == WCNT_W'(ROM_LAT - 1)) begin
            state <= COMPARE;
          end else begin
            waitCnt <= waitCnt + WCNT_W'(1);
          end
        end

        COMPARE: begin
          if (failPulse) begin
            rom_addr <= '0;
            digitCnt <= '0;
            busy     <= 1'b0;
            state    <= lockArm ? LOCKED : ENTRY;
          end else if (matchPulse) begin
            matched     <= 1'b1;
            player_addr <= rom_addr;
`ifdef IDAUTH_GUEST_EN
            is_guest    <= (rom_data == GUEST_ID);
`else
            is_guest    <= 1'b0;
`endif
            busy        <= 1'b0;
            state       <= MATCH;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            waitCnt  <= '0;
            state    <= WAIT;
          end
        end

        MATCH: begin
          if (logout) begin
            matched     <= 1'b0;
            is_guest    <= 1'b0;
            player_addr <= '0;
            rom_addr    <= '0;
            digitCnt    <= '0;
            state       <= ENTRY;
          end
        end

        LOCKED: begin
          if (lockDone) begin
            digitCnt <= '0;
            state    <= ENTRY;
          end
        end

        default: begin
          state <= ENTRY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_authenticator.sv
// tb_id_authenticator: directed plus randomized checks of id_authenticator
// (ADDR_W=3, ROM_LAT=2, MAX_FAILS=3, LOCK_CYCLES=1024) against a table-scan model.
module tb_id_authenticator;

  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int MAXF  = 3;
  localparam int LOCKC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_strobe;
  logic        digit_clear;
  logic        logout;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic        matched;
  logic [2:0]  player_addr;
  logic        is_guest;
  logic        locked;
  logic        busy;

  logic [15:0] rom [DEPTH];
  logic [15:0] romQ1;
  logic [15:0] romQ2;

  int tests = 0;
  int fails = 0;
  int modelFails = 0;

  always #5 clk = ~clk;

  // Two-stage synchronous ROM.
  always @(posedge clk) begin
    romQ1 <= rom[rom_addr];
    romQ2 <= romQ1;
  end
  assign rom_data = romQ2;

  id_authenticator #(
    .DIGITS(4), .DIGIT_W(4), .ADDR_W(3), .ROM_LAT(LAT),
    .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .digit_clear(digit_clear), .logout(logout), .rom_addr(rom_addr), .rom_data(rom_data),
    .matched(matched), .player_addr(player_addr), .is_guest(is_guest),
    .locked(locked), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStrobe(input logic [3:0] d);
    digit_in = d;
    digit_strobe = 1'b1;
    step();
    digit_strobe = 1'b0;
  endtask

  task automatic enterId(input logic [15:0] idv);
    for (int i = 0; i < 4; i++) pulseStrobe(idv[15-4*i -: 4]);
  endtask

  // Reference: scan table in order; sentinel ends, first equal word wins, each probe costs LAT+1.
  task automatic model(input logic [15:0] idv, output bit found, output int addr, output int edges);
    found = 1'b0;
    addr  = 0;
    edges = DEPTH * (LAT + 1);
    for (int a = 0; a < DEPTH; a++) begin
      if (rom[a] == 16'hFFFF) begin
        edges = (a + 1) * (LAT + 1);
        return;
      end
      if (rom[a] == idv) begin
        found = 1'b1;
        addr  = a;
        edges = (a + 1) * (LAT + 1);
        return;
      end
    end
  endtask

  task automatic runSearch(output int n, input bit stray);
    n = 0;
    if (stray) begin
      digit_in = 4'h9;
      digit_strobe = 1'b1;
    end
    do begin
      step();
      n++;
      digit_strobe = 1'b0;
    end while (busy && n < 100);
  endtask

  task automatic checkZeros(input string tag);
    check({tag, "_matched"}, 32'(matched), 32'd0);
    check({tag, "_player"}, 32'(player_addr), 32'd0);
    check({tag, "_guest"}, 32'(is_guest), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_romaddr"}, 32'(rom_addr), 32'd0);
  endtask

  task automatic lockSeq();
    int lc;
    check("lock_set", 32'(locked), 32'd1);
    lc = 0;
    for (int j = 0; j < 5; j++) begin
      digit_in = 4'(j + 1);
      digit_strobe = 1'b1;
      step();
      lc++;
    end
    digit_strobe = 1'b0;
    digit_clear = 1'b1;
    step();
    lc++;
    digit_clear = 1'b0;
    while (locked && lc < 3000) begin
      step();
      lc++;
    end
    check("lock_len", 32'(lc), 32'(LOCKC));
    check("lock_busy", 32'(busy), 32'd0);
    modelFails = 0;
  endtask

  task automatic attempt(input logic [15:0] idv, input bit stray);
    bit f;
    bit g;
    int a;
    int e;
    int n;
    model(idv, f, a, e);
    enterId(idv);
    check("busy_start", 32'(busy), 32'd1);
    runSearch(n, stray);
    check("latency", 32'(n), 32'(e));
    check("matched", 32'(matched), 32'(f));
    check("busy_end", 32'(busy), 32'd0);
    if (f) begin
`ifdef IDAUTH_GUEST_EN
      g = (rom[a] == 16'h8888);
`else
      g = 1'b0;
`endif
      modelFails = 0;
      check("player_addr", 32'(player_addr), 32'(a));
      check("is_guest", 32'(is_guest), 32'(g));
      check("rom_addr_hit", 32'(rom_addr), 32'(a));
      check("locked_hit", 32'(locked), 32'd0);
      repeat (3) step();
      check("match_hold", 32'(matched), 32'd1);
      logout = 1'b1;
      step();
      logout = 1'b0;
      check("logout_matched", 32'(matched), 32'd0);
      check("logout_player", 32'(player_addr), 32'd0);
      check("logout_guest", 32'(is_guest), 32'd0);
      check("logout_romaddr", 32'(rom_addr), 32'd0);
    end else begin
      modelFails++;
      check("rom_addr_fail", 32'(rom_addr), 32'd0);
      check("player_fail", 32'(player_addr), 32'd0);
      if (modelFails == MAXF) lockSeq();
      else check("locked_fail", 32'(locked), 32'd0);
    end
  endtask

  task automatic directedRom();
    rom[0] = 16'h1234;
    rom[1] = 16'h8888;
    rom[2] = 16'hFFFF;
    for (int a = 3; a < DEPTH; a++) rom[a] = 16'(16'hA000 + a);
  endtask

  initial begin
    int n;
    logic [15:0] idv;
    rst = 1'b0;
    digit_in = '0;
    digit_strobe = 1'b0;
    digit_clear = 1'b0;
    logout = 1'b0;
    directedRom();
    repeat (3) step();
    checkZeros("reset");
    rst = 1'b1;
    step();

    // Plain match, guest match with a stray strobe during busy.
    attempt(16'h1234, 1'b0);
    attempt(16'h8888, 1'b1);

    // Three sentinel misses lock; entry works again afterwards.
    repeat (3) attempt(16'h5555, 1'b0);
    attempt(16'h1234, 1'b0);

    // Clear discards partial entry; clear beats a simultaneous strobe.
    pulseStrobe(4'h1);
    pulseStrobe(4'h2);
    digit_clear = 1'b1;
    step();
    pulseStrobe(4'h3);
    digit_clear = 1'b1;
    digit_strobe = 1'b1;
    digit_in = 4'h7;
    step();
    digit_clear = 1'b0;
    digit_strobe = 1'b0;
    attempt(16'h1234, 1'b0);

    // Table without sentinel or hit: walks all addresses.
    for (int a = 0; a < DEPTH; a++) rom[a] = 16'(16'h1000 + a);
    attempt(16'h4321, 1'b0);

    // All-ones ID never matches.
    attempt(16'hFFFF, 1'b0);

    // Reset during WAIT and during MATCH.
    directedRom();
    enterId(16'h1234);
    step();
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    checkZeros("rst_wait");
    #2;
    rst = 1'b1;
    modelFails = 0;
    step();
    attempt(16'h1234, 1'b0);
    enterId(16'h8888);
    runSearch(n, 1'b0);
    check("pre_rst_match", 32'(matched), 32'd1);
    rst = 1'b0;
    #1;
    checkZeros("rst_match");
    #2;
    rst = 1'b1;
    step();
    attempt(16'h8888, 1'b0);

    // Randomized tables and IDs.
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        case ($urandom_range(0, 9))
          0: rom[a] = 16'hFFFF;
          1: rom[a] = 16'h8888;
          default: rom[a] = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 3) != 0) idv = rom[$urandom_range(0, DEPTH - 1)];
      else idv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) pulseStrobe(4'($urandom));
        digit_clear = 1'b1;
        step();
        digit_clear = 1'b0;
      end
      attempt(idv, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
